// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads instruction memory over a ready handshake and latches the IR.
// Two-state FSM (IDLE/READ) with all outputs registered; a branch arriving mid-read is parked until the read ends.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pc_load,
  input  logic [31:0]       pc_load_value,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [31:0]       instruction,
  output logic              ir_valid,
  output logic              fetch_err,
  output logic              busy,
  output logic [31:0]       pc
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  count;
  logic        pend_flag;
  logic [31:0] pend_val;
  logic [31:0] pc_done;
  logic [31:0] pc_abort;

  // A branch in the ending cycle beats any older parked branch, which beats the default.
  always_comb begin
    pc_done  = pc + 32'd1;
    pc_abort = pc;
    if (pc_load) begin
      pc_done  = pc_load_value;
      pc_abort = pc_load_value;
    end else if (pend_flag) begin
      pc_done  = pend_val;
      pc_abort = pend_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= 32'd0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      ir_valid    <= 1'b0;
      fetch_err   <= 1'b0;
      busy        <= 1'b0;
      count       <= 8'd0;
      pend_flag   <= 1'b0;
      pend_val    <= 32'd0;
    end else begin
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc <= pc_load_value;
          end
          if (start) begin
            mem_addr <= pc_load ? pc_load_value[ADDR_W-1:0] : pc[ADDR_W-1:0];
            mem_rd   <= 1'b1;
            count    <= 8'd0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (mem_ready) begin
            instruction <= mem_data_in;
            ir_valid    <= 1'b1;
            mem_rd      <= 1'b0;
            busy        <= 1'b0;
            pc          <= pc_done;
            pend_flag   <= 1'b0;
            state       <= IDLE;
          end else if (count == COUNT_LAST) begin
            fetch_err <= 1'b1;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            pc        <= pc_abort;
            pend_flag <= 1'b0;
            state     <= IDLE;
          end else begin
            count <= count + 8'd1;
            if (pc_load) begin
              pend_flag <= 1'b1;
              pend_val  <= pc_load_value;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
